apb4_master: RTL
================

APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 8, APB address width.
- DATA_WIDTH, default 32, APB data width (multiple of 8).
- TIMEOUT_CYCLES, default 16, max ACCESS wait cycles; 0 disables timeout.

REQ-002 The block SHALL use one clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte enables.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data (valid with rsp_valid).
- rsp_err  out  1  slave error or timeout.
- rsp_timeout  out  1  completion was a timeout abort.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB write strobes.
- pprot  out  3  APB protection.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Function
REQ-003 FSM SHALL have states IDLE, SETUP, ACCESS; all APB outputs SHALL be registered.
REQ-004 cmd_ready SHALL equal (state==IDLE) and be 0 while rst is high.
REQ-005 On cmd_valid&&cmd_ready at an edge: capture command, drive psel=1, penable=0, go SETUP.
REQ-006 SETUP SHALL last exactly one cycle, then ACCESS with penable=1, psel=1.
REQ-007 paddr, pwrite, pwdata, pstrb, pprot SHALL be held constant from SETUP through the last ACCESS cycle.
REQ-008 Read commands SHALL drive pstrb=0 and pwdata=0 regardless of cmd_strb/cmd_wdata.
REQ-009 ACCESS with pready=0 SHALL hold all APB outputs (wait state) and increment the wait counter.
REQ-010 ACCESS with pready=1 at an edge: next cycle psel=0, penable=0, state IDLE, rsp_valid=1, rsp_err=pslverr, rsp_timeout=0.
REQ-011 rsp_rdata SHALL capture prdata on read completion; write completion or error SHALL drive rsp_rdata=0.
REQ-012 If TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES with pready still 0: abort as REQ-010 with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-013 pready=1 on the timeout cycle SHALL take precedence: normal completion, no timeout.
REQ-014 The wait counter SHALL clear on entry to SETUP, be $clog2(TIMEOUT_CYCLES+1) bits wide and never wrap.
REQ-015 rsp_valid SHALL be high exactly one cycle per accepted command; rsp_* SHALL hold their values until the next completion.
REQ-016 Minimum command-to-command spacing SHALL be 3 cycles (IDLE accept, SETUP, ACCESS); no overlap of transfers.
REQ-017 pready/pslverr/prdata SHALL be ignored outside ACCESS.

Reset
REQ-018 rst high SHALL force IDLE and zero every output (psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_*), including mid-transfer; no rsp_valid SHALL be issued for an aborted transfer.
REQ-019 The first command SHALL be accepted no earlier than the first edge with rst low.

Verification
REQ-020 Write addr=0x04, wdata=0xDEADBEEF, strb=0xF, pready=1 immediately -> SETUP then ACCESS one cycle each; rsp_valid, rsp_err=0, 3-cycle total.
REQ-021 Read addr=0x08, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> outputs stable 4 ACCESS cycles; rsp_rdata=0x12345678, rsp_err=0.
REQ-022 Read with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0, pstrb=0 throughout.
REQ-023 pready held 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; pready rising on cycle 16 -> normal completion instead.
REQ-024 rst asserted during ACCESS wait -> next cycle psel=0, penable=0, cmd_ready=0; no rsp_valid; cmd_ready=1 after release.
REQ-025 cmd_valid held high for 4 back-to-back commands -> each accepted only in IDLE, 4 rsp_valid pulses, command order preserved.

Source files
------------

// File: rtl/apb4_master.sv
// APB4 master: one command in flight, IDLE -> SETUP -> ACCESS; min 3 cycles accept-to-accept, rsp_valid one cycle after final ACCESS.
// Backpressure: cmd_ready is high only in IDLE; slave wait states stretch ACCESS up to TIMEOUT_CYCLES (0 = wait forever).
module apb4_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
   input  logic [2:0]                cmd_prot,
   output logic                      rsp_valid,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_WIDTH-1:0]     paddr,
   output logic [DATA_WIDTH-1:0]     pwdata,
   output logic [DATA_WIDTH/8-1:0]   pstrb,
   output logic [2:0]                pprot,
   input  logic [DATA_WIDTH-1:0]     prdata,
   input  logic                      pready,
   input  logic                      pslverr
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   assign cmd_ready = (state == IDLE) && !rst;

   // This ACCESS cycle is the last one allowed without pready.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (int'(wait_cnt) == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk) begin
      rsp_valid <= 1'b0;
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         pprot       <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state    <= SETUP;
                  wait_cnt <= '0;
                  psel     <= 1'b1;
                  penable  <= 1'b0;
                  pwrite   <= cmd_write;
                  paddr    <= cmd_addr;
                  pprot    <= cmd_prot;
                  // Reads never expose stale write data or strobes on the bus.
                  pwdata   <= cmd_write ? cmd_wdata : '0;
                  pstrb    <= cmd_write ? cmd_strb  : '0;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
            end
            ACCESS: begin
               if (pready) begin
                  state       <= IDLE;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
               end else if (timeout_hit) begin
                  state       <= IDLE;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
                  wait_cnt    <= wait_cnt + CNT_W'(1);
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
            end
         endcase
      end
   end

endmodule
